// File: rtl/tdc_meas_ctrl_if.sv
// Configuration and result bundle between a burst controller (master) and
// the TDC measurement sequencer (slave).
interface tdc_meas_ctrl_if;
    logic        cfg_start;
    logic        cfg_abort;
    logic [7:0]  cfg_num_shots;
    logic [7:0]  cfg_timeout;
    logic        busy;
    logic        done;
    logic        res_valid;
    logic [20:0] res_sum;
    logic [7:0]  res_hits;
    logic [7:0]  res_miss;

    modport master (
        output cfg_start, cfg_abort, cfg_num_shots, cfg_timeout,
        input  busy, done, res_valid, res_sum, res_hits, res_miss
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_num_shots, cfg_timeout,
        output busy, done, res_valid, res_sum, res_hits, res_miss
    );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Burst sequencer for an external TDC: releases, fires, waits for a result or
// timeout, resets the TDC, and accumulates hit/miss statistics per burst.
module tdc_meas_ctrl #(
    parameter int START_W = 2,
    parameter int RST_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    tdc_meas_ctrl_if.slave    bus,
    output logic              tdc_start,
    output logic              tdc_rst_n,
    input  logic              tdc_valid,
    input  logic [12:0]       tdc_tof
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_FIRE,
        S_WAIT,
        S_RECOVER,
        S_DONE
    } state_t;

    localparam logic [3:0] START_LAST = 4'(START_W);
    localparam logic [3:0] RST_LAST   = 4'(RST_CYC);

    state_t      state_q;
    logic [2:0]  sync_q;
    logic [3:0]  phase_q;
    logic [8:0]  timer_q;
    logic [7:0]  shots_q;
    logic [7:0]  num_q;
    logic [7:0]  tmo_q;
    logic        tdc_start_q;
    logic        tdc_rst_n_q;
    logic        busy_q;
    logic        done_q;
    logic        res_valid_q;
    logic [20:0] res_sum_q;
    logic [7:0]  res_hits_q;
    logic [7:0]  res_miss_q;

    logic        vrise;
    logic [8:0]  tmo_lim;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge history.
    assign vrise   = sync_q[1] & ~sync_q[2];
    assign tmo_lim = (tmo_q == 8'd0) ? 9'd256 : {1'b0, tmo_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1], sync_q[0], tdc_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 4'd0;
            timer_q     <= 9'd0;
            shots_q     <= 8'd0;
            num_q       <= 8'd0;
            tmo_q       <= 8'd0;
            tdc_start_q <= 1'b0;
            tdc_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= 21'd0;
            res_hits_q  <= 8'd0;
            res_miss_q  <= 8'd0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && bus.cfg_abort) begin
                state_q     <= S_IDLE;
                tdc_start_q <= 1'b0;
                tdc_rst_n_q <= 1'b0;
                busy_q      <= 1'b0;
                res_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.cfg_start && !bus.cfg_abort) begin
                            num_q       <= bus.cfg_num_shots;
                            tmo_q       <= bus.cfg_timeout;
                            shots_q     <= 8'd0;
                            res_sum_q   <= 21'd0;
                            res_hits_q  <= 8'd0;
                            res_miss_q  <= 8'd0;
                            busy_q      <= 1'b1;
                            if (bus.cfg_num_shots == 8'd0) begin
                                state_q     <= S_DONE;
                                done_q      <= 1'b1;
                                res_valid_q <= 1'b1;
                            end else begin
                                state_q     <= S_RELEASE;
                                res_valid_q <= 1'b0;
                                tdc_rst_n_q <= 1'b1;
                                phase_q     <= 4'd1;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (phase_q == 4'd2) begin
                            state_q     <= S_FIRE;
                            tdc_start_q <= 1'b1;
                            phase_q     <= 4'd1;
                        end else begin
                            phase_q <= phase_q + 4'd1;
                        end
                    end
                    S_FIRE: begin
                        if (phase_q == START_LAST) begin
                            state_q     <= S_WAIT;
                            tdc_start_q <= 1'b0;
                            timer_q     <= 9'd1;
                        end else begin
                            phase_q <= phase_q + 4'd1;
                        end
                    end
                    S_WAIT: begin
                        // A capture wins over a timeout landing on the same cycle.
                        if (vrise || timer_q == tmo_lim) begin
                            if (vrise) begin
                                res_sum_q  <= res_sum_q + {8'd0, tdc_tof};
                                res_hits_q <= res_hits_q + 8'd1;
                            end else begin
                                res_miss_q <= res_miss_q + 8'd1;
                            end
                            state_q     <= S_RECOVER;
                            tdc_rst_n_q <= 1'b0;
                            shots_q     <= shots_q + 8'd1;
                            phase_q     <= 4'd1;
                        end else begin
                            timer_q <= timer_q + 9'd1;
                        end
                    end
                    S_RECOVER: begin
                        if (phase_q == RST_LAST) begin
                            if (shots_q == num_q) begin
                                state_q     <= S_DONE;
                                done_q      <= 1'b1;
                                res_valid_q <= 1'b1;
                            end else begin
                                state_q     <= S_RELEASE;
                                tdc_rst_n_q <= 1'b1;
                                phase_q     <= 4'd1;
                            end
                        end else begin
                            phase_q <= phase_q + 4'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tdc_start     = tdc_start_q;
    assign tdc_rst_n     = tdc_rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_hits  = res_hits_q;
    assign bus.res_miss  = res_miss_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomized bench for tdc_meas_ctrl: a TDC behavioural model answers each
// shot after a planned delay, and burst results are predicted per shot.
module tb_tdc_meas_ctrl;
    localparam int SW = 3;
    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tdc_start;
    logic        tdc_rst_n;
    logic        tdc_valid;
    logic [12:0] tdc_tof;

    tdc_meas_ctrl_if bus_if ();

    tdc_meas_ctrl #(.START_W(SW), .RST_CYC(RC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .tdc_start (tdc_start),
        .tdc_rst_n (tdc_rst_n),
        .tdc_valid (tdc_valid),
        .tdc_tof   (tdc_tof)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int plan_d   [256];
    int plan_tof [256];
    int exp_wait [256];
    int exp_n    = 0;
    int burst_id = 0;
    bit mon_en   = 1'b1;
    int rises    = 0;
    int waits    = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // TDC model plus output-waveform monitor, evaluated mid-cycle.
    initial begin
        logic [1:0] pat;
        logic [1:0] prev_pat;
        logic [1:0] pp;
        int  run;
        int  since;
        int  seen_burst;
        bit  armed;
        bit  chk_rec;
        bit  done_prev;
        tdc_valid  = 1'b0;
        tdc_tof    = 13'd0;
        prev_pat   = 2'b00;
        pp         = 2'b00;
        run        = 0;
        since      = 0;
        seen_burst = 0;
        armed      = 1'b0;
        chk_rec    = 1'b0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (burst_id != seen_burst) begin
                seen_burst = burst_id;
                rises   = 0;
                waits   = 0;
                chk_rec = 1'b0;
                armed   = 1'b0;
            end
            pat = {tdc_rst_n, tdc_start};
            if (pat != prev_pat) begin
                case (prev_pat)
                    2'b11: if (mon_en) chk("start_width", run, SW);
                    2'b10: begin
                        if (pp == 2'b11) begin
                            if (mon_en) chk("wait_len", run, exp_wait[waits]);
                            waits++;
                            chk_rec = mon_en && (waits < exp_n);
                        end else if (mon_en) begin
                            chk("release_len", run, 2);
                        end
                    end
                    default: begin
                        if (chk_rec && mon_en) chk("recover_len", run, RC);
                        chk_rec = 1'b0;
                    end
                endcase
                if (pat == 2'b11) begin
                    rises++;
                    since = 0;
                    armed = 1'b1;
                end
                pp       = prev_pat;
                prev_pat = pat;
                run      = 1;
            end else begin
                run++;
            end
            if (!tdc_rst_n) begin
                tdc_valid = 1'b0;
                armed     = 1'b0;
            end else if (armed && rises >= 1 && rises <= 256) begin
                if (since == plan_d[rises-1]) begin
                    tdc_valid = 1'b1;
                    tdc_tof   = 13'(plan_tof[rises-1]);
                    armed     = 1'b0;
                end
                since++;
            end
            if (bus_if.done && !done_prev) done_cnt++;
            done_prev = bus_if.done;
        end
    end

    task automatic run_burst(input int n, input int t, input int disturb);
        int teff;
        int sum;
        int hits;
        int miss;
        int cyc;
        int bound;
        teff = (t == 0) ? 256 : t;
        sum  = 0;
        hits = 0;
        miss = 0;
        for (int i = 0; i < n; i++) begin
            if (plan_d[i] >= SW - 2 && plan_d[i] <= SW + teff - 3) begin
                hits++;
                sum += plan_tof[i];
                exp_wait[i] = plan_d[i] + 3 - SW;
            end else begin
                miss++;
                exp_wait[i] = teff;
            end
        end
        exp_n = n;
        burst_id++;
        step();
        bus_if.cfg_num_shots = 8'(n);
        bus_if.cfg_timeout   = 8'(t);
        bus_if.cfg_start     = 1'b1;
        step();
        bus_if.cfg_start = 1'b0;
        chk("busy_after_start", bus_if.busy, 1);
        chk("res_valid_after_start", bus_if.res_valid, (n == 0) ? 1 : 0);
        bound = n * (10 + SW + RC + teff) + 20;
        cyc = 0;
        while (!bus_if.done && cyc < bound) begin
            if (cyc == disturb) begin
                bus_if.cfg_num_shots = 8'd9;
                bus_if.cfg_timeout   = 8'd3;
                bus_if.cfg_start     = 1'b1;
            end else if (cyc == disturb + 1) begin
                bus_if.cfg_start     = 1'b0;
                bus_if.cfg_num_shots = 8'(n);
                bus_if.cfg_timeout   = 8'(t);
            end
            step();
            cyc++;
        end
        bus_if.cfg_start = 1'b0;
        chk("done_seen", bus_if.done, 1);
        chk("res_sum", bus_if.res_sum, sum);
        chk("res_hits", bus_if.res_hits, hits);
        chk("res_miss", bus_if.res_miss, miss);
        chk("res_valid_at_done", bus_if.res_valid, 1);
        chk("busy_at_done", bus_if.busy, 1);
        chk("start_pulses", rises, n);
        step();
        chk("done_one_cycle", bus_if.done, 0);
        chk("res_valid_held", bus_if.res_valid, 1);
        chk("busy_after_done", bus_if.busy, 0);
    endtask

    initial begin
        int n;
        int t;
        int dc;
        int cyc;
        rst = 1'b1;
        bus_if.cfg_start     = 1'b0;
        bus_if.cfg_abort     = 1'b0;
        bus_if.cfg_num_shots = 8'd0;
        bus_if.cfg_timeout   = 8'd0;
        step();
        step();
        chk("rst_tdc_start", tdc_start, 0);
        chk("rst_tdc_rst_n", tdc_rst_n, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_done", bus_if.done, 0);
        chk("rst_res_valid", bus_if.res_valid, 0);
        chk("rst_res_sum", bus_if.res_sum, 0);
        chk("rst_res_hits", bus_if.res_hits, 0);
        chk("rst_res_miss", bus_if.res_miss, 0);
        rst = 1'b0;
        step();

        // Three captured shots.
        for (int i = 0; i < 3; i++) begin
            plan_d[i]   = 10;
            plan_tof[i] = 100 * (i + 1);
        end
        run_burst(3, 50, -1);

        // No TDC response at all.
        for (int i = 0; i < 4; i++) plan_d[i] = 1000;
        run_burst(4, 10, -1);

        // Capture coinciding with timeout, plus a cfg_start while busy.
        plan_d[0] = SW + 12 - 3; plan_tof[0] = 1234;
        plan_d[1] = 4;           plan_tof[1] = 77;
        run_burst(2, 12, 20);

        // Timeout code 0 gives a 256-cycle window.
        plan_d[0] = 1000; plan_tof[0] = 5;
        plan_d[1] = 200;  plan_tof[1] = 4321;
        run_burst(2, 0, -1);

        for (int b = 0; b < 10; b++) begin
            n = int'($urandom_range(1, 6));
            t = int'($urandom_range(3, 20));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) plan_d[i] = 1000;
                else plan_d[i] = int'($urandom_range(0, SW + t + 1));
                plan_tof[i] = int'($urandom_range(0, 8191));
            end
            run_burst(n, t, -1);
        end

        // Full-scale accumulation.
        for (int i = 0; i < 255; i++) begin
            plan_d[i]   = 5;
            plan_tof[i] = 8191;
        end
        run_burst(255, 8, -1);

        // Abort during the second WAIT.
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) plan_d[i] = 1000;
        exp_n = 5;
        burst_id++;
        step();
        bus_if.cfg_num_shots = 8'd5;
        bus_if.cfg_timeout   = 8'd10;
        bus_if.cfg_start     = 1'b1;
        step();
        bus_if.cfg_start = 1'b0;
        cyc = 0;
        while (!(rises == 2 && tdc_start == 1'b0 && tdc_rst_n == 1'b1) && cyc < 500) begin
            step();
            cyc++;
        end
        chk("abort_reach_wait2", (rises == 2 && tdc_start == 1'b0 && tdc_rst_n == 1'b1) ? 1 : 0, 1);
        repeat (3) step();
        bus_if.cfg_abort = 1'b1;
        step();
        bus_if.cfg_abort = 1'b0;
        chk("abort_busy", bus_if.busy, 0);
        chk("abort_tdc_rst_n", tdc_rst_n, 0);
        chk("abort_tdc_start", tdc_start, 0);
        chk("abort_res_valid", bus_if.res_valid, 0);
        chk("abort_done", bus_if.done, 0);
        dc = done_cnt;
        repeat (20) step();
        chk("abort_no_done", done_cnt, dc);
        chk("abort_stays_idle", bus_if.busy, 0);
        chk("abort_no_more_shots", rises, 2);
        mon_en = 1'b1;
        plan_d[0] = 3; plan_tof[0] = 11;
        plan_d[1] = 6; plan_tof[1] = 22;
        run_burst(2, 6, -1);

        // cfg_start together with cfg_abort in IDLE is ignored.
        bus_if.cfg_num_shots = 8'd1;
        bus_if.cfg_start     = 1'b1;
        bus_if.cfg_abort     = 1'b1;
        step();
        bus_if.cfg_start = 1'b0;
        bus_if.cfg_abort = 1'b0;
        chk("start_abort_busy", bus_if.busy, 0);
        repeat (3) step();
        chk("start_abort_tdc_rst_n", tdc_rst_n, 0);

        // Asynchronous reset in the middle of FIRE.
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) plan_d[i] = 1000;
        exp_n = 3;
        burst_id++;
        step();
        bus_if.cfg_num_shots = 8'd3;
        bus_if.cfg_timeout   = 8'd10;
        bus_if.cfg_start     = 1'b1;
        step();
        bus_if.cfg_start = 1'b0;
        cyc = 0;
        while (tdc_start != 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("fire_reached", tdc_start, 1);
        step();
        rst = 1'b1;
        #1;
        chk("async_rst_tdc_start", tdc_start, 0);
        chk("async_rst_tdc_rst_n", tdc_rst_n, 0);
        chk("async_rst_busy", bus_if.busy, 0);
        chk("async_rst_done", bus_if.done, 0);
        chk("async_rst_res_valid", bus_if.res_valid, 0);
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", bus_if.busy, 0);
        run_burst(0, 10, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
